// File: rtl/reduction_feeder_if.sv
// Handshake and data bundle between the reduction feeder, its producer,
// the tile accumulator and the result consumer.
interface reduction_feeder_if #(
  parameter int WIDTH         = 16,
  parameter int TILE_SIZE     = 129,
  parameter int PARALLEL_SIZE = 3,
  parameter int LEN_W         = 16
);
  localparam int VW = TILE_SIZE * WIDTH;

  logic                        cmd_valid_i;
  logic                        cmd_ready_o;
  logic [LEN_W-1:0]            cmd_len_i;
  logic [VW-1:0]               cmd_bias_i;
  logic                        vec_valid_i;
  logic                        vec_ready_o;
  logic [VW-1:0]               vec_data_i;
  logic                        acc_rst_o;
  logic [VW-1:0]               acc_init_o;
  logic [PARALLEL_SIZE*VW-1:0] operand_o;
  logic [VW-1:0]               acc_i;
  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [VW-1:0]               res_data_o;

  modport master (
    output cmd_valid_i, cmd_len_i, cmd_bias_i, vec_valid_i, vec_data_i, acc_i, res_ready_i,
    input  cmd_ready_o, vec_ready_o, acc_rst_o, acc_init_o, operand_o, res_valid_o, res_data_o
  );

  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_bias_i, vec_valid_i, vec_data_i, acc_i, res_ready_i,
    output cmd_ready_o, vec_ready_o, acc_rst_o, acc_init_o, operand_o, res_valid_o, res_data_o
  );
endinterface

// File: rtl/reduction_feeder.sv
// Sequencer for the tile reduction accumulator: seeds it with a bias, feeds
// vectors in zero-padded groups of PARALLEL_SIZE, then returns the final sum.
module reduction_feeder #(
  parameter int WIDTH         = 16,
  parameter int TILE_SIZE     = 129,
  parameter int PARALLEL_SIZE = 3,
  parameter int LEN_W         = 16
) (
  input logic          CLK_i,
  input logic          RST_i,
  reduction_feeder_if.slave bus
);
  localparam int VW  = TILE_SIZE * WIDTH;
  localparam int OPW = PARALLEL_SIZE * VW;
  localparam int CW  = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(PARALLEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [CW-1:0]    cnt_q;
  logic [VW-1:0]    stage_q [PARALLEL_SIZE];
  logic             acc_rst_q;
  logic [VW-1:0]    acc_init_q;
  logic [OPW-1:0]   operand_q;
  logic [OPW-1:0]   operand_d;
  logic             res_valid_q;
  logic [VW-1:0]    res_data_q;
  logic             vec_ready_s;
  logic             vec_accept_s;
  logic             last_s;
  logic             close_s;

  assign vec_ready_s  = (state_q == S_FEED) && (remaining_q != {LEN_W{1'b0}});
  assign vec_accept_s = bus.vec_valid_i && vec_ready_s;
  assign last_s       = (remaining_q == LEN_W'(1));
  assign close_s      = vec_accept_s && ((cnt_q == LAST_SLOT) || last_s);

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.vec_ready_o = vec_ready_s;
  assign bus.acc_rst_o   = acc_rst_q;
  assign bus.acc_init_o  = acc_init_q;
  assign bus.operand_o   = operand_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;

  // Group image: staged slots, then the incoming vector, then +0.0 padding.
  always_comb begin
    operand_d = {OPW{1'b0}};
    for (int k = 0; k < PARALLEL_SIZE; k++) begin
      if (CW'(k) < cnt_q) begin
        operand_d[k*VW +: VW] = stage_q[k];
      end else if (CW'(k) == cnt_q) begin
        operand_d[k*VW +: VW] = bus.vec_data_i;
      end else begin
        operand_d[k*VW +: VW] = {VW{1'b0}};
      end
    end
  end

  // Sequencer state, staging and all registered outputs.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q     <= S_IDLE;
      remaining_q <= {LEN_W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      acc_rst_q   <= 1'b1;
      acc_init_q  <= {VW{1'b0}};
      operand_q   <= {OPW{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {VW{1'b0}};
      for (int k = 0; k < PARALLEL_SIZE; k++) begin
        stage_q[k] <= {VW{1'b0}};
      end
    end else begin
      operand_q <= {OPW{1'b0}};
      acc_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          acc_rst_q <= 1'b1;
          if (bus.cmd_valid_i) begin
            remaining_q <= bus.cmd_len_i;
            acc_init_q  <= bus.cmd_bias_i;
            cnt_q       <= {CW{1'b0}};
            state_q     <= S_INIT;
          end
        end
        S_INIT: begin
          state_q <= (remaining_q != {LEN_W{1'b0}}) ? S_FEED : S_WAIT;
        end
        S_FEED: begin
          if (vec_accept_s) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (close_s) begin
              operand_q <= operand_d;
              cnt_q     <= {CW{1'b0}};
            end else begin
              for (int k = 0; k < PARALLEL_SIZE; k++) begin
                if (CW'(k) == cnt_q) begin
                  stage_q[k] <= bus.vec_data_i;
                end
              end
              cnt_q <= cnt_q + CW'(1);
            end
            if (last_s) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Last group was added on the previous edge, so acc_i is final here.
          res_data_q  <= bus.acc_i;
          res_valid_q <= 1'b1;
          state_q     <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.res_ready_i) begin
            res_valid_q <= 1'b0;
            acc_rst_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule
